// File: rtl/serial_subtractor_stepper.sv
// Bit-serial 5-bit subtractor stepped by a debounced push button.
// A - B is computed LSB first, one bit per KEY[1] press, with the borrow
// carried between presses. Each difference bit is shown on its own HEX
// digit and LEDR bit; the final borrow (sign) appears on HEX5 / LEDR[9].

// Synchronizes one active-low key, debounces it and emits a single-cycle
// pulse when an accepted press (1 -> 0) is seen.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Down-counter restarts on every match with the accepted level, so only an
  // uninterrupted run of DEBOUNCE_CYCLES differing clocks changes the level.
  always_comb begin
    meta_d  = key_n;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = RELOAD;
    if (sync_q != level_q) begin
      if (cnt_q == '0) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
    pulse_d = level_q & ~level_d;
  end

  // Released (1) is the accepted level out of reset so no spurious press.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= RELOAD;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// State  | Meaning
// -------+------------------------------------------------------------
// IDLE   | cleared; waiting for the first step (bit 0 uses live SW)
// RUN    | operands latched; idx = next bit to compute (1..4)
// DONE   | all bits computed; sign shown; steps ignored until clear
module serial_subtractor_stepper #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [2:0] LAST_IDX  = 3'(WIDTH - 1);

  logic step_pulse;
  logic clear_pulse;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
    .clk         (MAX10_CLK1_50),
    .reset       (reset),
    .key_n       (KEY[1]),
    .press_pulse (step_pulse)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .clk         (MAX10_CLK1_50),
    .reset       (reset),
    .key_n       (KEY[0]),
    .press_pulse (clear_pulse)
  );

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]       idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;

  logic bit_a;
  logic bit_b;
  logic bit_bin;
  logic bit_d;
  logic bit_bout;

  // State and datapath registers; reset dominates everything else.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
    end
  end

  // One full-subtractor cell; the first bit reads the switches directly
  // because the operands are only latched on that same edge.
  always_comb begin
    if (state_q == S_IDLE) begin
      bit_a   = SW[0];
      bit_b   = SW[5];
      bit_bin = 1'b0;
    end else begin
      bit_a   = op_a_q[idx_q];
      bit_b   = op_b_q[idx_q];
      bit_bin = borrow_q;
    end
    bit_d    = bit_a ^ bit_b ^ bit_bin;
    bit_bout = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bit_bin);
  end

  // Next-state: clear beats step, so a simultaneous press computes nothing.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    if (clear_pulse) begin
      state_d  = S_IDLE;
      op_a_d   = '0;
      op_b_d   = '0;
      idx_d    = '0;
      borrow_d = 1'b0;
      diff_d   = '0;
    end else if (step_pulse) begin
      case (state_q)
        S_IDLE: begin
          op_a_d    = SW[4:0];
          op_b_d    = SW[9:5];
          diff_d    = '0;
          diff_d[0] = bit_d;
          borrow_d  = bit_bout;
          idx_d     = 3'd1;
          state_d   = S_RUN;
        end
        S_RUN: begin
          diff_d[idx_q] = bit_d;
          borrow_d      = bit_bout;
          idx_d         = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end
        end
        default: begin
          // DONE (and any unused encoding) holds until clear or reset.
        end
      endcase
    end
  end

  logic [6:0] hex_dig [WIDTH];
  logic       done;

  // Display decode: a digit lights only once its bit has been computed.
  always_comb begin
    hex_dig = '{default: SEG_BLANK};
    done    = (state_q == S_DONE);
    for (int i = 0; i < WIDTH; i++) begin
      if (3'(i) < idx_q) begin
        hex_dig[i] = diff_q[i] ? SEG_ONE : SEG_ZERO;
      end
    end
    LEDR = {done & borrow_q, done, 3'b000, diff_q};
    HEX0 = hex_dig[0];
    HEX1 = hex_dig[1];
    HEX2 = hex_dig[2];
    HEX3 = hex_dig[3];
    HEX4 = hex_dig[4];
    HEX5 = (done & borrow_q) ? SEG_DASH : SEG_BLANK;
  end

endmodule

// File: tb/tb_serial_subtractor_stepper.sv
// Bench for the bit-serial subtractor stepper. Stimulus pushes the expected
// display snapshot {LEDR, HEX5..HEX0} before each action; a monitor pops and
// compares whenever the outputs change, or when a quiet-time probe is asked.
module tb_serial_subtractor_stepper;

  localparam int DB = 4;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sw = '0;
  logic [1:0] key = 2'b11;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  always #5 clk = ~clk;

  serial_subtractor_stepper #(.WIDTH(5), .DEBOUNCE_CYCLES(DB)) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .SW            (sw),
    .KEY           (key),
    .LEDR          (ledr),
    .HEX0          (hex0),
    .HEX1          (hex1),
    .HEX2          (hex2),
    .HEX3          (hex3),
    .HEX4          (hex4),
    .HEX5          (hex5)
  );

  wire [51:0] snap = {ledr, hex5, hex4, hex3, hex2, hex1, hex0};

  logic [51:0] exp_q [$];
  string       name_q [$];
  int          tests = 0;
  int          fails = 0;
  int          probe_req = 0;

  // Hand-computed per-step difference bits (only bits computed so far).
  logic [4:0] d13_6 [5] = '{5'b00001, 5'b00011, 5'b00111, 5'b00111, 5'b00111};
  logic [4:0] d6_13 [5] = '{5'b00001, 5'b00001, 5'b00001, 5'b01001, 5'b11001};
  logic [4:0] d31_0 [5] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};

  function automatic logic [51:0] mk(input logic [4:0] diff, input int ndig,
                                     input bit done, input bit fb);
    logic [6:0] h [6];
    logic [9:0] l;
    for (int i = 0; i < 5; i++) h[i] = (i < ndig) ? (diff[i] ? S1 : S0) : SB;
    h[5] = (done && fb) ? SD : SB;
    l = {done && fb, done, 3'b000, diff};
    return {l, h[5], h[4], h[3], h[2], h[1], h[0]};
  endfunction

  task automatic check(input string nm, input logic [51:0] got, input logic [51:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got LEDR=%b HEX5..0=%h, expected LEDR=%b HEX5..0=%h",
               nm, got[51:42], got[41:0], want[51:42], want[41:0]);
    end
  endtask

  // Monitor: an output change (or a pending probe) consumes one expectation.
  initial begin
    logic [51:0] prev;
    logic [51:0] want;
    string       nm;
    int          seen;
    bit          take;
    seen = 0;
    @(negedge clk);
    prev = snap;
    forever begin
      @(negedge clk);
      take = 1'b0;
      if (snap !== prev) begin
        take = 1'b1;
      end else if (probe_req != seen) begin
        take = 1'b1;
        seen++;
      end
      if (take) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_change: got LEDR=%b HEX5..0=%h, expected no change",
                   snap[51:42], snap[41:0]);
        end else begin
          want = exp_q.pop_front();
          nm   = name_q.pop_front();
          check(nm, snap, want);
        end
      end
      prev = snap;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [51:0] v, input string nm);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic probe(input logic [51:0] v, input string nm);
    expect_out(v, nm);
    probe_req++;
    tick(2);
  endtask

  task automatic press(input int which, input int hold);
    key[which] = 1'b0;
    tick(hold);
    key[which] = 1'b1;
    tick(12);
  endtask

  task automatic press_both(input int hold);
    key = 2'b00;
    tick(hold);
    key = 2'b11;
    tick(12);
  endtask

  task automatic run_steps(input logic [4:0] d [5], input int first, input int last,
                           input bit fb, input string nm);
    for (int k = first; k <= last; k++) begin
      expect_out(mk(d[k], k + 1, k == 4, fb), $sformatf("%s_step%0d", nm, k + 1));
      press(1, 10);
    end
  endtask

  task automatic do_clear(input string nm);
    expect_out(mk(5'b0, 0, 1'b0, 1'b0), nm);
    press(0, 10);
  endtask

  initial begin
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    probe(mk(5'b0, 0, 1'b0, 1'b0), "reset_state");

    // 13 - 6 = 7, no final borrow; a sixth press in DONE changes nothing.
    sw = {5'd6, 5'd13};
    run_steps(d13_6, 0, 4, 1'b0, "a13_b6");
    press(1, 10);
    probe(mk(5'b00111, 5, 1'b1, 1'b0), "done_sixth_press_ignored");
    do_clear("clear_after_a13_b6");

    // 6 - 13 = 25 mod 32, final borrow shown on HEX5 / LEDR[9].
    sw = {5'd13, 5'd6};
    run_steps(d6_13, 0, 4, 1'b1, "a6_b13");
    do_clear("clear_after_a6_b13");

    // A press one clock short of the debounce window must not step.
    sw = {5'd6, 5'd13};
    press(1, DB - 1);
    tick(10);
    probe(mk(5'b0, 0, 1'b0, 1'b0), "bounce_no_step");

    // Long hold gives exactly one step; then switches change mid-run.
    press(1, 1);
    tick(1);
    expect_out(mk(d13_6[0], 1, 1'b0, 1'b0), "held_key_one_step");
    press(1, 10 * DB);
    probe(mk(d13_6[0], 1, 1'b0, 1'b0), "held_key_still_one");
    run_steps(d13_6, 1, 1, 1'b0, "sw_change");
    sw = {5'd31, 5'd0};
    run_steps(d13_6, 2, 4, 1'b0, "sw_change");
    do_clear("clear_after_sw_change");

    // Simultaneous clear and step mid-run: clear wins, nothing computed.
    sw = {5'd6, 5'd13};
    run_steps(d13_6, 0, 1, 1'b0, "pre_both");
    expect_out(mk(5'b0, 0, 1'b0, 1'b0), "clear_and_step_together");
    press_both(10);
    probe(mk(5'b0, 0, 1'b0, 1'b0), "idle_after_both");
    sw = {5'd0, 5'd31};
    run_steps(d31_0, 0, 4, 1'b0, "a31_b0");
    do_clear("clear_after_a31_b0");

    // Reset mid-run lands in the same cleared state.
    sw = {5'd13, 5'd6};
    run_steps(d6_13, 0, 1, 1'b1, "pre_reset");
    expect_out(mk(5'b0, 0, 1'b0, 1'b0), "reset_mid_run");
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    probe(mk(5'b0, 0, 1'b0, 1'b0), "idle_after_reset");

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick(1);
    while (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got no output update, expected one", name_q.pop_front());
      void'(exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
